gate_bist: RTL and testbench

Built-in self-test sequencer for a single two-input logic gate (for example an AND built from NAND stages). It drives the gate's inputs through all four input combinations and samples the gate output after a programmable settle time. Each sample is compared against the expected truth table for a selected function, and the block reports error count, first failing vector and pass/fail. It is the stimulus-and-checker end of the gate interface and sits between a control register block and the gate under test.

---
 rtl/gate_bist.sv | 160 ++++++++++++++++
 tb/tb_gate_bist.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - BIST sequencer for a two-input gate
// Sweeps {a,b} through 00..11, samples tst_y after SETTLE cycles and scores against func.
module gate_bist #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       func,
  output logic             tst_a,
  output logic             tst_b,
  input  logic             tst_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [1:0]       fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [CW-1:0]    C_RELOAD = CW'(SETTLE - 1);
  localparam logic [LW-1:0]    L_LAST   = LW'(LOOPS - 1);
  localparam logic [ERR_W-1:0] E_MAX    = {ERR_W{1'b1}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state;
  logic [2:0]       r_func, w_func;
  logic [1:0]       r_vec, w_vec;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [LW-1:0]    r_loop, w_loop;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic [ERR_W-1:0] r_err, w_err, w_err_s;
  logic             r_fail_seen, w_fail_seen;
  logic [1:0]       r_fail_vec, w_fail_vec;
  logic             w_exp, w_mismatch;

  always_comb begin
    w_exp = 1'b0;
    case (r_func)
      3'd0: w_exp = r_vec[1] & r_vec[0];
      3'd1: w_exp = ~(r_vec[1] & r_vec[0]);
      3'd2: w_exp = r_vec[1] | r_vec[0];
      3'd3: w_exp = ~(r_vec[1] | r_vec[0]);
      3'd4: w_exp = r_vec[1] ^ r_vec[0];
      3'd5: w_exp = ~(r_vec[1] ^ r_vec[0]);
      3'd6: w_exp = r_vec[1];
      default: w_exp = ~r_vec[1];
    endcase
    w_mismatch = (tst_y != w_exp);
    // err count including the sample on this edge, saturating
    if (w_mismatch && (r_err != E_MAX)) w_err_s = r_err + ERR_W'(1);
    else                                w_err_s = r_err;
  end

  always_comb begin
    w_state     = r_state;
    w_func      = r_func;
    w_vec       = r_vec;
    w_cnt       = r_cnt;
    w_loop      = r_loop;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_pass      = r_pass;
    w_err       = r_err;
    w_fail_seen = r_fail_seen;
    w_fail_vec  = r_fail_vec;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state     = S_RUN;
          w_func      = func;
          w_err       = '0;
          w_fail_seen = 1'b0;
          w_fail_vec  = 2'b00;
          w_pass      = 1'b0;
          w_vec       = 2'b00;
          w_loop      = '0;
          w_cnt       = C_RELOAD;
          w_busy      = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_vec   = 2'b00;
          w_pass  = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - CW'(1);
        end else begin
          w_err = w_err_s;
          if (w_mismatch && !r_fail_seen) begin
            w_fail_seen = 1'b1;
            w_fail_vec  = r_vec;
          end
          if (r_vec != 2'b11) begin
            w_vec = r_vec + 2'b01;
            w_cnt = C_RELOAD;
          end else if (r_loop != L_LAST) begin
            w_loop = r_loop + LW'(1);
            w_vec  = 2'b00;
            w_cnt  = C_RELOAD;
          end else begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_err_s == '0);
            w_vec   = 2'b00;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_func      <= 3'd0;
      r_vec       <= 2'b00;
      r_cnt       <= '0;
      r_loop      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_fail_seen <= 1'b0;
      r_fail_vec  <= 2'b00;
    end else begin
      r_state     <= w_state;
      r_func      <= w_func;
      r_vec       <= w_vec;
      r_cnt       <= w_cnt;
      r_loop      <= w_loop;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_err       <= w_err;
      r_fail_seen <= w_fail_seen;
      r_fail_vec  <= w_fail_vec;
    end
  end

  assign tst_a     = r_vec[1];
  assign tst_b     = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_seen = r_fail_seen;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - directed bench for gate_bist
// Three instances: A (SETTLE=2,LOOPS=1), B (LOOPS=3, 11 stuck low), C (ERR_W=2, LOOPS=2).
module tb_gate_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       a_start = 0, a_abort = 0;
  logic [2:0] a_func = 0;
  logic       a_ta, a_tb, a_y, a_busy, a_done, a_pass, a_fs;
  logic [7:0] a_err;
  logic [1:0] a_fv;
  int         a_model = 0;
  always_comb begin
    a_y = a_ta & a_tb;
    if (a_model == 1) a_y = a_ta ^ a_tb;
  end

  logic       b_start = 0, b_abort = 0;
  logic [2:0] b_func = 0;
  logic       b_ta, b_tb, b_y, b_busy, b_done, b_pass, b_fs;
  logic [7:0] b_err;
  logic [1:0] b_fv;
  // AND gate whose 11 response is stuck low reads 0 on every vector
  assign b_y = 1'b0;

  logic       c_start = 0, c_abort = 0;
  logic [2:0] c_func = 0;
  logic       c_ta, c_tb, c_y, c_busy, c_done, c_pass, c_fs;
  logic [1:0] c_err;
  logic [1:0] c_fv;
  assign c_y = c_ta & c_tb;

  gate_bist #(.SETTLE(2), .LOOPS(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .func(a_func),
    .tst_a(a_ta), .tst_b(a_tb), .tst_y(a_y), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_cnt(a_err), .fail_seen(a_fs), .fail_vec(a_fv));

  gate_bist #(.SETTLE(2), .LOOPS(3), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .func(b_func),
    .tst_a(b_ta), .tst_b(b_tb), .tst_y(b_y), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_cnt(b_err), .fail_seen(b_fs), .fail_vec(b_fv));

  gate_bist #(.SETTLE(2), .LOOPS(2), .ERR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .func(c_func),
    .tst_a(c_ta), .tst_b(c_tb), .tst_y(c_y), .busy(c_busy), .done(c_done),
    .pass(c_pass), .err_cnt(c_err), .fail_seen(c_fs), .fail_vec(c_fv));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_ta, a_tb, a_busy, a_done, a_pass, a_fs} !== 6'b0) begin
      fails++; $display("FAIL reset_a_flags got=%b exp=000000", {a_ta, a_tb, a_busy, a_done, a_pass, a_fs});
    end
    tests++;
    if ({a_err, a_fv} !== 10'd0) begin
      fails++; $display("FAIL reset_a_err_vec got=%h/%b exp=0/00", a_err, a_fv);
    end
    tests++;
    if ({b_busy, b_done, b_err, c_busy, c_done, c_err} !== 14'd0) begin
      fails++; $display("FAIL reset_bc got=%b exp=0", {b_busy, b_done, b_err, c_busy, c_done, c_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_truth_table();
    logic [2:0] f_t [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd6, 3'd7};
    int         m_t [6] = '{0, 1, 0, 1, 0, 0};
    logic [7:0] e_t [6] = '{8'd0, 8'd0, 8'd4, 8'd4, 8'd1, 8'd3};
    logic [1:0] v_t [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      a_model = m_t[i];
      a_func  = f_t[i];
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tests++;
        if ({a_busy, a_done, a_ta, a_tb} !== {1'b1, 1'b0, 2'(k / 2)}) begin
          fails++; $display("FAIL tt%0d_stim_k%0d got=%b exp=%b", i, k, {a_busy, a_done, a_ta, a_tb}, {1'b1, 1'b0, 2'(k / 2)});
        end
        @(negedge clk);
      end
      tests++;
      if ({a_done, a_busy, a_pass} !== {1'b1, 1'b0, (e_t[i] == 8'd0)}) begin
        fails++; $display("FAIL tt%0d_done got=%b exp=%b", i, {a_done, a_busy, a_pass}, {1'b1, 1'b0, (e_t[i] == 8'd0)});
      end
      tests++;
      if ({a_err, a_fs, a_fv} !== {e_t[i], (e_t[i] != 8'd0), v_t[i]}) begin
        fails++; $display("FAIL tt%0d_result got=%h/%b/%b exp=%h/%b/%b", i, a_err, a_fs, a_fv, e_t[i], (e_t[i] != 8'd0), v_t[i]);
      end
      @(negedge clk);
      tests++;
      if (a_done !== 1'b0) begin
        fails++; $display("FAIL tt%0d_done_pulse got=%b exp=0", i, a_done);
      end
    end
  endtask

  task automatic test_stuck_loops();
    int bad = 0;
    b_func  = 3'd0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if ({b_busy, b_done, b_ta, b_tb} !== {1'b1, 1'b0, 2'((k / 2) % 4)}) bad++;
      b_start = (k == 5);
      @(negedge clk);
    end
    b_start = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL stuck_sweep bad_cycles=%0d exp=0", bad);
    end
    tests++;
    if ({b_done, b_busy, b_pass} !== 3'b100) begin
      fails++; $display("FAIL stuck_done got=%b exp=100", {b_done, b_busy, b_pass});
    end
    tests++;
    if ({b_err, b_fs, b_fv} !== {8'd3, 1'b1, 2'b11}) begin
      fails++; $display("FAIL stuck_result got=%0d/%b/%b exp=3/1/11", b_err, b_fs, b_fv);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    c_func  = 3'd1;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if ({c_busy, c_err} !== {1'b1, 2'd3}) begin
      fails++; $display("FAIL sat_mid got=%b/%0d exp=1/3", c_busy, c_err);
    end
    repeat (8) @(negedge clk);
    tests++;
    if ({c_done, c_busy, c_pass, c_err, c_fs, c_fv} !== {3'b100, 2'd3, 1'b1, 2'b00}) begin
      fails++; $display("FAIL sat_done got=%b exp=%b", {c_done, c_busy, c_pass, c_err, c_fs, c_fv}, {3'b100, 2'd3, 1'b1, 2'b00});
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    a_model = 0;
    a_func  = 3'd1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({a_ta, a_tb, a_err} !== {2'b10, 8'd2}) begin
      fails++; $display("FAIL abort_pre got=%b/%0d exp=10/2", {a_ta, a_tb}, a_err);
    end
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    tests++;
    if ({a_busy, a_done, a_ta, a_tb, a_pass} !== 5'b0) begin
      fails++; $display("FAIL abort_idle got=%b exp=00000", {a_busy, a_done, a_ta, a_tb, a_pass});
    end
    tests++;
    if ({a_err, a_fs, a_fv} !== {8'd2, 1'b1, 2'b00}) begin
      fails++; $display("FAIL abort_hold got=%0d/%b/%b exp=2/1/00", a_err, a_fs, a_fv);
    end
    a_abort = 1'b1;
    repeat (2) @(negedge clk);
    a_abort = 1'b0;
    tests++;
    if ({a_done, a_busy, a_err} !== {2'b00, 8'd2}) begin
      fails++; $display("FAIL abort_in_idle got=%b/%0d exp=00/2", {a_done, a_busy}, a_err);
    end
    a_func  = 3'd0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if ({a_done, a_pass, a_err, a_fs} !== {2'b11, 8'd0, 1'b0}) begin
      fails++; $display("FAIL abort_rerun got=%b/%b/%0d/%b exp=1/1/0/0", a_done, a_pass, a_err, a_fs);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    a_func  = 3'd1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_busy, a_err} !== {1'b1, 8'd1}) begin
      fails++; $display("FAIL rst_mid_pre got=%b/%0d exp=1/1", a_busy, a_err);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_busy, a_done, a_pass, a_ta, a_tb, a_fs, a_fv, a_err} !== 16'd0) begin
      fails++; $display("FAIL rst_mid_async got=%b exp=0", {a_busy, a_done, a_pass, a_ta, a_tb, a_fs, a_fv, a_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_busy, a_done} !== 2'b00) begin
      fails++; $display("FAIL rst_mid_nodone got=%b exp=00", {a_busy, a_done});
    end
  endtask

  task automatic test_back_to_back();
    a_model = 0;
    a_func  = 3'd0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if ({a_done, a_pass} !== 2'b11) begin
      fails++; $display("FAIL b2b_first got=%b exp=11", {a_done, a_pass});
    end
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    tests++;
    if ({a_done, a_busy, a_ta, a_tb, a_pass} !== 5'b01000) begin
      fails++; $display("FAIL b2b_restart got=%b exp=01000", {a_done, a_busy, a_ta, a_tb, a_pass});
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({a_ta, a_tb} !== 2'b01) begin
      fails++; $display("FAIL b2b_vec1 got=%b exp=01", {a_ta, a_tb});
    end
    repeat (6) @(negedge clk);
    tests++;
    if ({a_done, a_busy, a_pass, a_err} !== {3'b101, 8'd0}) begin
      fails++; $display("FAIL b2b_second got=%b/%0d exp=101/0", {a_done, a_busy, a_pass}, a_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_stuck_loops();
    test_saturate();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
